// File: rtl/i2c_target_regfile_if.sv
// rtl/i2c_target_regfile_if.sv - local register port of the I2C target register file
interface i2c_target_regfile_if;
    logic       local_we;
    logic [7:0] local_addr;
    logic [7:0] local_wdata;
    logic [7:0] local_rdata;
    logic       i2c_wr_strobe;
    logic [7:0] i2c_wr_addr;
    logic [7:0] i2c_wr_data;
    logic       busy;

    modport master (
        output local_we, local_addr, local_wdata,
        input  local_rdata, i2c_wr_strobe, i2c_wr_addr, i2c_wr_data, busy
    );

    modport slave (
        input  local_we, local_addr, local_wdata,
        output local_rdata, i2c_wr_strobe, i2c_wr_addr, i2c_wr_data, busy
    );
endinterface

// File: rtl/i2c_target_regfile.sv
// rtl/i2c_target_regfile.sv - I2C target exposing a byte-addressed register file
module i2c_target_regfile #(
    parameter logic [6:0] DEVICE_ADDRESS = 7'h44,
    parameter int         NUM_REGS       = 16,
    parameter int         SYNC_STAGES    = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 scl,
    inout  wire                  sda,
    i2c_target_regfile_if.slave  lp
);
    localparam int         PTR_W    = $clog2(NUM_REGS);
    localparam logic [7:0] IDX_MASK = 8'(NUM_REGS - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_PTR,
        S_PTR_ACK,
        S_WDATA,
        S_WDATA_ACK,
        S_RDATA,
        S_RACK
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_det, stop_det;

    state_t             state_q, state_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [7:0]         shift_q, shift_d;
    logic [7:0]         tx_q, tx_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               sda_oe_q, sda_oe_d;
    logic               busy_q, busy_d;
    logic               rw_q, rw_d;
    logic               nack_q, nack_d;
    logic               strobe_q, strobe_d;
    logic [7:0]         wr_addr_q, wr_addr_d;
    logic [7:0]         wr_data_q, wr_data_d;
    logic               commit_we;
    logic [7:0]         regs_q [NUM_REGS];
    logic [7:0]         snap;
    logic [7:0]         local_rd;
    logic [7:0]         local_rdata_q;

    // Bus idles high, so the synchronisers reset to 1 to avoid a false START/STOP.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    assign snap = regs_q[ptr_q];

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        ptr_d     = ptr_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        rw_d      = rw_q;
        nack_d    = nack_q;
        strobe_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        commit_we = 1'b0;

        if (stop_det) begin
            state_d   = S_IDLE;
            busy_d    = 1'b0;
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
        end else if (start_det) begin
            state_d   = S_ADDR;
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: ;
                S_ADDR, S_PTR, S_WDATA: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = '0;
                        sda_oe_d  = 1'b1;
                        if (state_q == S_ADDR) begin
                            if (shift_q[7:1] == DEVICE_ADDRESS) begin
                                busy_d  = 1'b1;
                                rw_d    = shift_q[0];
                                state_d = S_ADDR_ACK;
                            end else begin
                                busy_d   = 1'b0;
                                sda_oe_d = 1'b0;
                                state_d  = S_IDLE;
                            end
                        end else if (state_q == S_PTR) begin
                            ptr_d   = shift_q[PTR_W-1:0];
                            state_d = S_PTR_ACK;
                        end else begin
                            commit_we = 1'b1;
                            strobe_d  = 1'b1;
                            wr_addr_d = 8'(ptr_q);
                            wr_data_d = shift_q;
                            ptr_d     = ptr_q + PTR_W'(1);
                            state_d   = S_WDATA_ACK;
                        end
                    end
                end
                S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                        if (state_q == S_ADDR_ACK && rw_q) begin
                            tx_d     = snap;
                            sda_oe_d = ~snap[7];
                            ptr_d    = ptr_q + PTR_W'(1);
                            state_d  = S_RDATA;
                        end else if (state_q == S_ADDR_ACK) begin
                            state_d = S_PTR;
                        end else begin
                            state_d = S_WDATA;
                        end
                    end
                end
                S_RDATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd7) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = S_RACK;
                        end else begin
                            // Rotate rather than shift so the next bit is always at [7].
                            tx_d      = {tx_q[6:0], tx_q[7]};
                            sda_oe_d  = ~tx_q[6];
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                S_RACK: begin
                    if (scl_rise) begin
                        nack_d = sda_s;
                    end else if (scl_fall) begin
                        if (!nack_q) begin
                            tx_d      = snap;
                            sda_oe_d  = ~snap[7];
                            ptr_d     = ptr_q + PTR_W'(1);
                            bit_cnt_d = '0;
                            state_d   = S_RDATA;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= '0;
            ptr_q     <= '0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            rw_q      <= 1'b0;
            nack_q    <= 1'b0;
            strobe_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ptr_q     <= ptr_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            rw_q      <= rw_d;
            nack_q    <= nack_d;
            strobe_q  <= strobe_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // A bus commit to the same register as a local write takes precedence.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (commit_we && ptr_q == PTR_W'(i)) begin
                    regs_q[i] <= shift_q;
                end else if (lp.local_we && (lp.local_addr & IDX_MASK) == 8'(i)) begin
                    regs_q[i] <= lp.local_wdata;
                end
            end
        end
    end

    always_comb begin
        local_rd = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if ((lp.local_addr & IDX_MASK) == 8'(i)) begin
                local_rd = regs_q[i];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            local_rdata_q <= '0;
        end else begin
            local_rdata_q <= local_rd;
        end
    end

    assign sda              = sda_oe_q ? 1'b0 : 1'bz;
    assign lp.local_rdata   = local_rdata_q;
    assign lp.i2c_wr_strobe = strobe_q;
    assign lp.i2c_wr_addr   = wr_addr_q;
    assign lp.i2c_wr_data   = wr_data_q;
    assign lp.busy          = busy_q;
endmodule

// File: tb/tb_i2c_target_regfile.sv
// tb/tb_i2c_target_regfile.sv - bus-level bench for i2c_target_regfile
module tb_i2c_target_regfile;
    localparam int QC = 10;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic scl     = 1'b1;
    logic sda_low = 1'b0;
    wire  sda;

    pullup (sda);
    assign sda = sda_low ? 1'b0 : 1'bz;

    i2c_target_regfile_if lp_if ();

    i2c_target_regfile #(
        .DEVICE_ADDRESS(7'h44),
        .NUM_REGS      (16),
        .SYNC_STAGES   (2)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .scl    (scl),
        .sda    (sda),
        .lp     (lp_if)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] exp_wr_q [$];
    logic [15:0] obs_wr_q [$];
    logic [7:0]  exp_rd_q [$];

    always @(negedge clock) begin
        if (lp_if.i2c_wr_strobe) obs_wr_q.push_back({lp_if.i2c_wr_addr, lp_if.i2c_wr_data});
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic q();
        repeat (QC) @(posedge clock);
        #1;
    endtask

    task automatic i2c_start();
        sda_low = 1'b0; q();
        scl = 1'b1;     q();
        sda_low = 1'b1; q();
        scl = 1'b0;     q();
    endtask

    task automatic i2c_stop();
        sda_low = 1'b1; q();
        scl = 1'b1;     q();
        sda_low = 1'b0; q();
    endtask

    task automatic send_bit(input logic v);
        sda_low = ~v; q();
        scl = 1'b1;   q();
        scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b, input logic collide, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        if (collide) begin
            repeat (2) @(posedge clock);
            #1;
            lp_if.local_we    = 1'b1;
            lp_if.local_addr  = 8'h03;
            lp_if.local_wdata = 8'hEE;
            @(posedge clock);
            #1;
            lp_if.local_we = 1'b0;
            @(posedge clock);
            #1;
            check_val("t6_rdata_next", lp_if.local_rdata, 8'h77);
        end
        sda_low = 1'b0; q();
        scl = 1'b1;     q();
        ack = sda;
        scl = 1'b0;     q();
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        sda_low = 1'b0;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            q();
            scl = 1'b1; q();
            b = {b[6:0], sda};
            scl = 1'b0;
        end
        sda_low = ~nack; q();
        scl = 1'b1;      q();
        scl = 1'b0;      q();
        sda_low = 1'b0;
    endtask

    task automatic local_write(input logic [7:0] a, input logic [7:0] d);
        lp_if.local_we    = 1'b1;
        lp_if.local_addr  = a;
        lp_if.local_wdata = d;
        @(posedge clock);
        #1;
        lp_if.local_we = 1'b0;
    endtask

    task automatic local_read(input logic [7:0] a, output logic [7:0] d);
        lp_if.local_addr = a;
        @(posedge clock);
        #1;
        d = lp_if.local_rdata;
    endtask

    task automatic compare_strobes(input string tag);
        logic [15:0] o, e;
        check_val({tag, "_count"}, obs_wr_q.size(), exp_wr_q.size());
        while (obs_wr_q.size() > 0 && exp_wr_q.size() > 0) begin
            o = obs_wr_q.pop_front();
            e = exp_wr_q.pop_front();
            check_val({tag, "_strobe"}, o, e);
        end
        obs_wr_q.delete();
        exp_wr_q.delete();
    endtask

    task automatic read_expect(input string tag, input int n);
        logic [7:0] d, e;
        for (int i = 0; i < n; i++) begin
            read_byte(i == n - 1, d);
            e = exp_rd_q.pop_front();
            check_val(tag, d, e);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic       ack;
        logic [7:0] d;

        lp_if.local_we    = 1'b0;
        lp_if.local_addr  = '0;
        lp_if.local_wdata = '0;
        repeat (3) @(posedge clock);
        #1;
        check_val("rst_sda", sda, 1'b1);
        check_val("rst_busy", lp_if.busy, 1'b0);
        check_val("rst_strobe", lp_if.i2c_wr_strobe, 1'b0);
        check_val("rst_wr_addr", lp_if.i2c_wr_addr, 8'h00);
        check_val("rst_wr_data", lp_if.i2c_wr_data, 8'h00);
        check_val("rst_rdata", lp_if.local_rdata, 8'h00);
        reset_n = 1'b1;
        q();
        local_read(8'h01, d);
        check_val("rst_reg1", d, 8'h00);

        // 1: pointer write then two data bytes
        i2c_start();
        write_byte(8'h88, 1'b0, ack); check_val("t1_addr_ack", ack, 1'b0);
        check_val("t1_busy", lp_if.busy, 1'b1);
        write_byte(8'h01, 1'b0, ack); check_val("t1_ptr_ack", ack, 1'b0);
        exp_wr_q.push_back(16'h010D);
        write_byte(8'h0D, 1'b0, ack); check_val("t1_d0_ack", ack, 1'b0);
        exp_wr_q.push_back(16'h023F);
        write_byte(8'h3F, 1'b0, ack); check_val("t1_d1_ack", ack, 1'b0);
        i2c_stop();
        check_val("t1_busy_stop", lp_if.busy, 1'b0);
        compare_strobes("t1");
        local_read(8'h01, d); check_val("t1_reg1", d, 8'h0D);
        local_read(8'h02, d); check_val("t1_reg2", d, 8'h3F);

        // 2: preload, pointer, repeated START, sequential read
        for (int i = 0; i < 6; i++) local_write(8'(9 + i), 8'((i + 1) * 8'h11));
        i2c_start();
        write_byte(8'h88, 1'b0, ack); check_val("t2_addr_ack", ack, 1'b0);
        write_byte(8'h09, 1'b0, ack); check_val("t2_ptr_ack", ack, 1'b0);
        i2c_start();
        write_byte(8'h89, 1'b0, ack); check_val("t2_raddr_ack", ack, 1'b0);
        for (int i = 0; i < 6; i++) exp_rd_q.push_back(8'((i + 1) * 8'h11));
        read_expect("t2_rd", 6);
        check_val("t2_sda_rel", sda, 1'b1);
        check_val("t2_busy", lp_if.busy, 1'b1);
        i2c_stop();
        check_val("t2_busy_stop", lp_if.busy, 1'b0);
        compare_strobes("t2");

        // 3: foreign address is ignored
        i2c_start();
        write_byte(8'h8A, 1'b0, ack); check_val("t3_addr_nack", ack, 1'b1);
        check_val("t3_busy", lp_if.busy, 1'b0);
        write_byte(8'h01, 1'b0, ack); check_val("t3_b1_nack", ack, 1'b1);
        write_byte(8'h99, 1'b0, ack); check_val("t3_b2_nack", ack, 1'b1);
        check_val("t3_busy_end", lp_if.busy, 1'b0);
        i2c_stop();
        compare_strobes("t3");
        local_read(8'h01, d); check_val("t3_reg1", d, 8'h0D);

        // 4: pointer wrap on read, then pointer retained across STOP
        local_write(8'h0F, 8'hA5);
        local_write(8'h00, 8'h5A);
        i2c_start();
        write_byte(8'h88, 1'b0, ack);
        write_byte(8'h0F, 1'b0, ack); check_val("t4_ptr_ack", ack, 1'b0);
        i2c_start();
        write_byte(8'h89, 1'b0, ack); check_val("t4_raddr_ack", ack, 1'b0);
        exp_rd_q.push_back(8'hA5);
        exp_rd_q.push_back(8'h5A);
        read_expect("t4_rd", 2);
        i2c_stop();
        i2c_start();
        write_byte(8'h89, 1'b0, ack); check_val("t4_raddr2_ack", ack, 1'b0);
        exp_rd_q.push_back(8'h0D);
        read_expect("t4_ptr_end", 1);
        i2c_stop();
        compare_strobes("t4");

        // 5a: STOP in the middle of a data byte
        local_write(8'h07, 8'h5C);
        i2c_start();
        write_byte(8'h88, 1'b0, ack);
        write_byte(8'h07, 1'b0, ack); check_val("t5_ptr_ack", ack, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        q();
        i2c_stop();
        compare_strobes("t5");
        local_read(8'h07, d); check_val("t5_reg7", d, 8'h5C);

        // 5b: reset while driving a 0 read bit
        i2c_start();
        write_byte(8'h88, 1'b0, ack);
        write_byte(8'h05, 1'b0, ack);
        i2c_start();
        write_byte(8'h89, 1'b0, ack); check_val("t5_raddr_ack", ack, 1'b0);
        check_val("t5_bit0_low", sda, 1'b0);
        reset_n = 1'b0;
        #1;
        check_val("t5_rst_sda", sda, 1'b1);
        check_val("t5_rst_busy", lp_if.busy, 1'b0);
        scl = 1'b1;
        sda_low = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        reset_n = 1'b1;
        q();
        local_read(8'h07, d); check_val("t5_reg7_clr", d, 8'h00);

        // 6: bus commit and local write to reg 3 in the same cycle
        i2c_start();
        write_byte(8'h88, 1'b0, ack);
        write_byte(8'h03, 1'b0, ack); check_val("t6_ptr_ack", ack, 1'b0);
        exp_wr_q.push_back(16'h0377);
        write_byte(8'h77, 1'b1, ack); check_val("t6_d_ack", ack, 1'b0);
        i2c_stop();
        compare_strobes("t6");
        local_read(8'h03, d); check_val("t6_reg3", d, 8'h77);

        check_val("rd_queue_empty", exp_rd_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
